// File: rtl/timer_chain_pkg.sv
// Shared constants for the countdown timer: digit width and radix values,
// plus the default MM:SS modulus vector (digit 0 in the low nibble).
package timer_chain_pkg;

  localparam int DW_DEF     = 4;
  localparam int RADIX_DEC  = 10;
  localparam int RADIX_SEXT = 6;

  // min-tens, min-units, sec-tens, sec-units
  localparam logic [15:0] RADIX_MMSS = {4'(RADIX_SEXT), 4'(RADIX_DEC),
                                        4'(RADIX_SEXT), 4'(RADIX_DEC)};

  // A DW-bit radix field of all zeros stands for the full 2^DW modulus.
  function automatic int field_to_mod(input int field, input int dw);
    return (field == 0) ? (1 << dw) : field;
  endfunction

endpackage

// File: rtl/timer_digit.sv
// One down-counting digit of modulus MOD: clamped parallel load and
// decrement that reloads MOD-1 when it borrows out of zero.
module timer_digit #(
  parameter int DW  = 4,
  parameter int MOD = 10
)(
  input  logic          clock,
  input  logic          clrn,
  input  logic          load,
  input  logic [DW-1:0] ld_val,
  input  logic          dec,
  output logic [DW-1:0] q,
  output logic          is_zero
);

  localparam logic [DW-1:0] MAX = DW'(MOD - 1);

  logic over;

  // Compare one bit wider so a modulus of 2^DW never clamps.
  assign over    = ({1'b0, ld_val} >= (DW+1)'(MOD));
  assign is_zero = (q == '0);

  // Digit register: load beats decrement; out-of-range loads saturate to MAX.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn)     q <= '0;
    else if (load) q <= over ? MAX : ld_val;
    else if (dec)  q <= is_zero ? MAX : q - DW'(1);
  end

endmodule

// File: rtl/timer_chain.sv
// Multi-digit mixed-radix countdown timer. Digits borrow from the digit
// above when every lower digit is zero; all-zero either holds or wraps.
module timer_chain
  import timer_chain_pkg::*;
#(
  parameter int                 NDIG  = 4,
  parameter int                 DW    = DW_DEF,
  parameter logic [NDIG*DW-1:0] RADIX = RADIX_MMSS,
  parameter bit                 WRAP  = 1'b0
)(
  input  logic               clock,
  input  logic               clrn,
  input  logic               loadn,
  input  logic               enable,
  input  logic [NDIG*DW-1:0] data,
  output logic [NDIG*DW-1:0] digits,
  output logic               zero,
  output logic               tc,
  output logic               done
);

  logic [NDIG-1:0] is_zero;
  logic [NDIG-1:0] borrow;
  logic [NDIG-1:0] dec;
  logic            step;
  logic            load;
  logic            upper_zero;
  logic            at_one;

  assign load = ~loadn;
  assign step = loadn & enable;
  assign zero = &is_zero;
  assign tc   = enable & zero;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam int MOD = field_to_mod(int'(RADIX[DW*i +: DW]), DW);

    if (i == 0) begin : g_lsb
      assign borrow[i] = 1'b1;
    end else begin : g_up
      assign borrow[i] = &is_zero[i-1:0];
    end

    // At all-zero a step only proceeds in wrap mode, where every digit
    // borrows and reloads its max in one go.
    assign dec[i] = step & borrow[i] & (~zero | WRAP);

    timer_digit #(
      .DW  (DW),
      .MOD (MOD)
    ) u_digit (
      .clock   (clock),
      .clrn    (clrn),
      .load    (load),
      .ld_val  (data[DW*i +: DW]),
      .dec     (dec[i]),
      .q       (digits[DW*i +: DW]),
      .is_zero (is_zero[i])
    );
  end

  if (NDIG == 1) begin : g_one
    assign upper_zero = 1'b1;
  end else begin : g_many
    assign upper_zero = &is_zero[NDIG-1:1];
  end

  // The only value a single step takes to all-zero is exactly one.
  assign at_one = (digits[DW-1:0] == DW'(1)) & upper_zero;

  // Completion pulse lines up with the first cycle digits read all-zero.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) done <= 1'b0;
    else       done <= step & at_one;
  end

endmodule

// File: tb/tb_timer_chain.sv
// Bench for timer_chain (default MM:SS), one hold-mode and one wrap-mode
// instance driven by the same stimulus and checked against an integer model.
module tb_timer_chain;

  logic        clock  = 1'b0;
  logic        clrn   = 1'b0;
  logic        loadn  = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] data   = '0;

  logic [15:0] dig0, dig1;
  logic        zero0, tc0, done0, zero1, tc1, done1;

  int ncmp  = 0;
  int nfail = 0;

  localparam int RAD[4] = '{10, 6, 10, 6};
  localparam int TOTAL  = 3600;

  // model: count held as seconds-equivalent integer
  int m0 = 0, m1 = 0;
  bit ed0 = 0, ed1 = 0;

  always #5 clock = ~clock;

  timer_chain #(.WRAP(1'b0)) u_hold (
    .clock(clock), .clrn(clrn), .loadn(loadn), .enable(enable), .data(data),
    .digits(dig0), .zero(zero0), .tc(tc0), .done(done0)
  );

  timer_chain #(.WRAP(1'b1)) u_wrap (
    .clock(clock), .clrn(clrn), .loadn(loadn), .enable(enable), .data(data),
    .digits(dig1), .zero(zero1), .tc(tc1), .done(done1)
  );

  function automatic int load_val(input logic [15:0] d);
    int v = 0, w = 1, dg;
    for (int i = 0; i < 4; i++) begin
      dg = int'(d[4*i +: 4]);
      if (dg >= RAD[i]) dg = RAD[i] - 1;
      v += dg * w;
      w *= RAD[i];
    end
    return v;
  endfunction

  function automatic logic [15:0] to_digits(input int val);
    logic [15:0] r = '0;
    int v = val;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % RAD[i]);
      v = v / RAD[i];
    end
    return r;
  endfunction

  task automatic model_edge(input logic ln, input logic en, input logic [15:0] d);
    if (!ln) begin
      m0 = load_val(d); m1 = m0; ed0 = 0; ed1 = 0;
    end else if (en) begin
      ed0 = (m0 == 1); ed1 = (m1 == 1);
      m0 = (m0 == 0) ? 0 : m0 - 1;
      m1 = (m1 == 0) ? TOTAL - 1 : m1 - 1;
    end else begin
      ed0 = 0; ed1 = 0;
    end
  endtask

  task automatic model_clear();
    m0 = 0; m1 = 0; ed0 = 0; ed1 = 0;
  endtask

  task automatic step(input logic ln, input logic en, input logic [15:0] d);
    @(negedge clock);
    loadn = ln; enable = en; data = d;
    @(posedge clock);
    model_edge(ln, en, d);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    loadn = 1'b1; enable = 1'b0;
    #1 clrn = 1'b0;
    #1;
    ncmp++; if (dig0 !== 16'h0000) begin nfail++; $display("FAIL reset_digits: got %h want 0000", dig0); end
    ncmp++; if (zero0 !== 1'b1) begin nfail++; $display("FAIL reset_zero: got %b want 1", zero0); end
    ncmp++; if (done0 !== 1'b0 || done1 !== 1'b0) begin nfail++; $display("FAIL reset_done: got %b/%b want 0/0", done0, done1); end
    ncmp++; if (tc0 !== 1'b0) begin nfail++; $display("FAIL reset_tc_idle: got %b want 0", tc0); end
    enable = 1'b1;
    #1;
    ncmp++; if (tc0 !== 1'b1 || tc1 !== 1'b1) begin nfail++; $display("FAIL reset_tc_en: got %b/%b want 1/1", tc0, tc1); end
    @(negedge clock);
    clrn = 1'b1; enable = 1'b0;
    model_clear();
    step(1'b1, 1'b1, 16'h0000);
    ncmp++; if (dig0 !== 16'h0000) begin nfail++; $display("FAIL idle_tick_hold: got %h want 0000", dig0); end
    ncmp++; if (tc0 !== 1'b1) begin nfail++; $display("FAIL idle_tick_tc: got %b want 1", tc0); end
    ncmp++; if (dig1 !== 16'h5959 || done1 !== 1'b0) begin nfail++; $display("FAIL idle_tick_wrap: got %h/%b want 5959/0", dig1, done1); end
    ncmp++; if (done0 !== 1'b0) begin nfail++; $display("FAIL idle_tick_done: got %b want 0", done0); end
  endtask

  task automatic test_borrow();
    step(1'b0, 1'b0, 16'h1000);
    ncmp++; if (dig0 !== 16'h1000 || zero0 !== 1'b0) begin nfail++; $display("FAIL load_1000: got %h z=%b want 1000 z=0", dig0, zero0); end
    step(1'b1, 1'b1, 16'h0000);
    ncmp++; if (dig0 !== 16'h0959) begin nfail++; $display("FAIL borrow_0959: got %h want 0959", dig0); end
    step(1'b1, 1'b0, 16'h0000);
    ncmp++; if (dig0 !== 16'h0959) begin nfail++; $display("FAIL hold_0959: got %h want 0959", dig0); end
    step(1'b0, 1'b0, 16'h0100);
    step(1'b1, 1'b1, 16'h0000);
    ncmp++; if (dig0 !== 16'h0059 || dig1 !== 16'h0059) begin nfail++; $display("FAIL borrow_0059: got %h/%h want 0059", dig0, dig1); end
  endtask

  task automatic test_completion();
    step(1'b0, 1'b0, 16'h0002);
    step(1'b1, 1'b1, 16'h0000);
    ncmp++; if (dig0 !== 16'h0001 || done0 !== 1'b0) begin nfail++; $display("FAIL done_0001: got %h/%b want 0001/0", dig0, done0); end
    step(1'b1, 1'b1, 16'h0000);
    ncmp++; if (dig0 !== 16'h0000 || done0 !== 1'b1 || done1 !== 1'b1) begin nfail++; $display("FAIL done_pulse: got %h/%b/%b want 0000/1/1", dig0, done0, done1); end
    step(1'b1, 1'b1, 16'h0000);
    ncmp++; if (dig0 !== 16'h0000 || done0 !== 1'b0) begin nfail++; $display("FAIL done_after: got %h/%b want 0000/0", dig0, done0); end
    ncmp++; if (dig1 !== 16'h5959 || done1 !== 1'b0) begin nfail++; $display("FAIL done_wrap_after: got %h/%b want 5959/0", dig1, done1); end
    step(1'b0, 1'b1, 16'h0000);
    ncmp++; if (done0 !== 1'b0 || dig0 !== 16'h0000) begin nfail++; $display("FAIL load_zero_done: got %h/%b want 0000/0", dig0, done0); end
  endtask

  task automatic test_clamp();
    step(1'b0, 1'b1, 16'h7F9C);
    ncmp++; if (dig0 !== 16'h5959 || dig1 !== 16'h5959) begin nfail++; $display("FAIL clamp_priority: got %h/%h want 5959", dig0, dig1); end
    ncmp++; if (done0 !== 1'b0) begin nfail++; $display("FAIL clamp_done: got %b want 0", done0); end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'h0000);
    ncmp++; if (dig1 !== 16'h5959 || done1 !== 1'b0 || zero1 !== 1'b0) begin nfail++; $display("FAIL wrap_step: got %h/%b/%b want 5959/0/0", dig1, done1, zero1); end
    ncmp++; if (dig0 !== 16'h0000) begin nfail++; $display("FAIL hold_at_zero: got %h want 0000", dig0); end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 16'h0317);
    step(1'b1, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 16'h0000);
    ncmp++; if (dig0 !== 16'h0315) begin nfail++; $display("FAIL count_0315: got %h want 0315", dig0); end
    #2 clrn = 1'b0;
    #1;
    ncmp++; if (dig0 !== 16'h0000 || dig1 !== 16'h0000 || done0 !== 1'b0) begin nfail++; $display("FAIL async_clear: got %h/%h/%b want 0000/0000/0", dig0, dig1, done0); end
    @(negedge clock);
    clrn = 1'b1; enable = 1'b0;
    model_clear();
    step(1'b0, 1'b0, 16'h0001);
    step(1'b1, 1'b1, 16'h0000);
    ncmp++; if (done0 !== 1'b1) begin nfail++; $display("FAIL pre_reset_done: got %b want 1", done0); end
    #2 clrn = 1'b0;
    #1;
    ncmp++; if (done0 !== 1'b0 || done1 !== 1'b0) begin nfail++; $display("FAIL async_done_lost: got %b/%b want 0/0", done0, done1); end
    @(negedge clock);
    clrn = 1'b1; enable = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    logic        ln, en;
    logic [15:0] d;
    for (int n = 0; n < 400; n++) begin
      ln = ($urandom_range(0, 9) != 0);
      en = ($urandom_range(0, 3) != 0);
      d  = 16'($urandom);
      case ($urandom_range(0, 3))
        0: d = d & 16'h000F;
        1: d = d & 16'h00FF;
        default: ;
      endcase
      step(ln, en, d);
      ncmp++; if (dig0 !== to_digits(m0)) begin nfail++; $display("FAIL rand_digits_hold[%0d]: got %h want %h", n, dig0, to_digits(m0)); end
      ncmp++; if (dig1 !== to_digits(m1)) begin nfail++; $display("FAIL rand_digits_wrap[%0d]: got %h want %h", n, dig1, to_digits(m1)); end
      ncmp++; if (done0 !== ed0 || done1 !== ed1) begin nfail++; $display("FAIL rand_done[%0d]: got %b/%b want %b/%b", n, done0, done1, ed0, ed1); end
      ncmp++; if (zero0 !== (m0 == 0) || zero1 !== (m1 == 0)) begin nfail++; $display("FAIL rand_zero[%0d]: got %b/%b want %b/%b", n, zero0, zero1, m0 == 0, m1 == 0); end
      ncmp++; if (tc0 !== (en && m0 == 0) || tc1 !== (en && m1 == 0)) begin nfail++; $display("FAIL rand_tc[%0d]: got %b/%b", n, tc0, tc1); end
    end
  endtask

  initial begin
    test_reset();
    test_borrow();
    test_completion();
    test_clamp();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
